// File: rtl/ram_display_controller.sv
// ram_display_controller
// Shares one RAM address/write port between a user write requester and a
// paced playback scheduler. Each playback step fetches one RAM word, waits
// for the RAM and ROM read latencies, then pulses the shift-register enable.
// All outputs come straight from registers loaded from the next-state decode.

module ram_display_controller #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 5,
    parameter int LAST_ADDR = 31,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              play,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              shift_en,
    output logic              wr_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] play_ptr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        FETCH    = 3'd2,
        WAIT_RAM = 3'd3,
        WAIT_ROM = 3'd4,
        SHIFT    = 3'd5
    } state_t;

    localparam int                PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]  PTR_LAST   = ADDR_W'(LAST_ADDR);

    state_t              state_r;
    state_t              state_next_s;
    logic                fetch_start_s;
    logic                tick_s;
    logic [PRESC_W-1:0]  presc_r;
    logic                tick_pend_r;
    logic [ADDR_W-1:0]   play_ptr_r;
    logic [ADDR_W-1:0]   play_ptr_next_s;
    logic                ram_we_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic [DATA_W-1:0]   ram_wdata_r;
    logic                shift_en_r;
    logic                wr_ack_r;
    logic                busy_r;

    // The prescaler only advances while playing, so a paused tick is held.
    assign tick_s = play && (presc_r == PRESC_LAST);

    // Next-state decode: writes win over a pending tick; a fetch always runs to SHIFT.
    always_comb begin
        state_next_s  = state_r;
        fetch_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_req) begin
                    state_next_s = WRITE;
                end else if (tick_pend_r) begin
                    state_next_s  = FETCH;
                    fetch_start_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE:    state_next_s = IDLE;
            FETCH:    state_next_s = WAIT_RAM;
            WAIT_RAM: state_next_s = WAIT_ROM;
            WAIT_ROM: state_next_s = SHIFT;
            SHIFT:    state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // Playback pointer advances (with wrap) as the SHIFT cycle completes.
    always_comb begin
        play_ptr_next_s = play_ptr_r;
        if (state_r == SHIFT) begin
            if (play_ptr_r == PTR_LAST) begin
                play_ptr_next_s = {ADDR_W{1'b0}};
            end else begin
                play_ptr_next_s = play_ptr_r + ADDR_W'(1'b1);
            end
        end else begin
            play_ptr_next_s = play_ptr_r;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Playback prescaler: wraps at terminal count, frozen while paused.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (play) begin
            presc_r <= presc_r + PRESC_W'(1'b1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Single pending-tick flag; a fresh tick wins over the clear so none is dropped.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            tick_pend_r <= 1'b0;
        end else if (tick_s) begin
            tick_pend_r <= 1'b1;
        end else if (fetch_start_s) begin
            tick_pend_r <= 1'b0;
        end else begin
            tick_pend_r <= tick_pend_r;
        end
    end

    // Playback pointer register.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            play_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            play_ptr_r <= play_ptr_next_s;
        end
    end

    // Output registers loaded from the state being entered, so each output is
    // valid for exactly the cycle spent in that state.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            shift_en_r  <= 1'b0;
            wr_ack_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ram_we_r    <= (state_next_s == WRITE);
            wr_ack_r    <= (state_next_s == WRITE);
            ram_addr_r  <= (state_next_s == WRITE) ? wr_addr : play_ptr_next_s;
            ram_wdata_r <= (state_next_s == WRITE) ? wr_data : {DATA_W{1'b0}};
            shift_en_r  <= (state_next_s == SHIFT);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign shift_en  = shift_en_r;
    assign wr_ack    = wr_ack_r;
    assign busy      = busy_r;
    assign play_ptr  = play_ptr_r;

endmodule
